avg_req_arbiter: RTL and testbench
==================================

// Module: avg_req_arbiter
// PURPOSE
//  Shares one 4-sample averaging datapath among NUM_REQ asynchronous producers.
//  Each producer uses a 4-phase req/ack handshake. The block synchronises every
//  req, grants one producer at a time in round-robin order and captures its
//  data. It accumulates SAMPLES captures per producer, then emits that
//  producer's average tagged with its index. Sits between producer ports and
//  the downstream average consumer.
// PARAMETERS
//  NUM_REQ  4  number of producers (2..8)
//  DW       4  sample and average width, in bits
//  SAMPLES  4  samples per average; must be a power of 2
//  LOG2S    2  log2(SAMPLES); accumulator width is DW+LOG2S
// PORTS
//  clk_2      in   1            single clock; all logic on its rising edge
//  reset_n    in   1            asynchronous active-low reset
//  req        in   NUM_REQ      per-producer request; asynchronous to clk_2
//  data       in   NUM_REQ*DW   flat bus; producer i uses [i*DW +: DW]; stable while req[i]=1
//  ack        out  NUM_REQ      per-producer acknowledge, registered
//  avg_valid  out  1            one-cycle pulse: avg_data and avg_src are valid
//  avg_data   out  DW           floor(sum of SAMPLES samples / SAMPLES)
//  avg_src    out  clog2(NUM_REQ)  index of the producer that avg_data belongs to
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - ack=0, avg_valid=0, avg_data=0, avg_src=0.
//   - Sync flops=0, state=IDLE, rr pointer=0.
//   - All per-producer accumulators and counters=0.
//  Sync: each req bit passes through 2 flops (req_s); the FSM sees only req_s.
//  FSM states:
//   - IDLE: if any req_s, latch the rr winner into gnt -> CAPTURE; else stay.
//   - CAPTURE (1 cycle):
//     - acc[gnt] += data[gnt]; cnt[gnt]++; set ack[gnt]=1 -> RELEASE.
//     - If cnt[gnt] was SAMPLES-1: next cycle avg_valid=1,
//       avg_data=(acc+data)>>LOG2S, avg_src=gnt; clear acc[gnt] and cnt[gnt].
//   - RELEASE: hold ack[gnt]=1 until req_s[gnt]=0. Then clear ack[gnt],
//     set rr pointer=gnt+1 (wrap at NUM_REQ) -> IDLE.
//  Round-robin: search starts at the rr pointer. First req_s set wins.
//   Simultaneous requests are therefore served in cyclic order; no starvation.
//  Latency: req rises at edge k; ack is high after edge k+4 (2 sync, IDLE, CAPTURE).
//  Invariants:
//   - At most one ack bit is high at any time.
//   - ack never falls before the synchronised req falls.
//  Arithmetic: accumulator is DW+LOG2S bits and cannot overflow
//   (max 4*15 = 60 < 64). Average is truncated (floor), no rounding.
//  Boundaries:
//   - req falls before it is granted: ignored, no capture.
//   - Producer re-raises req while its ack is still high: protocol violation,
//     ignored until ack=0.
//   - Per-producer counters are independent; interleaved producers never mix sums.
//   - avg_valid is a single pulse with no back-pressure. The consumer must
//     accept it in that cycle.
//   - reset_n low mid-handshake: ack drops immediately; partial sums discarded.
// STRUCTURE
//  - Package avg_arb_pkg: state encodings (IDLE=2'd0, CAPTURE=2'd1,
//    RELEASE=2'd2) and default widths DW, LOG2S.
//  - Sub-module avg_rr_pick: combinational round-robin picker.
//    Inputs: req_s, pointer. Outputs: any, winner index.
//  - Accumulators, counters, FSM and output registers stay in the top level.
// TESTING
//  1. P0 sends 3,5,7,9 -> one avg_valid: avg_data=6, avg_src=0.
//     ack rises 4 cycles after each req.
//  2. P2 sends 1,1,1,2 (sum 5) -> avg_data=1 (floor).
//     P3 sends 15 x4 -> avg_data=15, no overflow.
//  3. After reset, req=4'b1111 held through repeated handshakes
//     -> grant order 0,1,2,3,0,1,...; ack is never multi-hot.
//  4. P1 and P2 alternate, P1: 2,4,6,8 and P2: 8,8,8,8
//     -> avg 5 with src 1, then avg 8 with src 2; no cross-mixing.
//  5. reset_n pulsed low while ack[1]=1 after 2 of P1's samples
//     -> ack=0 at once; the next 4 samples (4 each) give avg 4.
//  6. Glitch: req[0] high for 1 cycle, then low
//     -> no ack if not captured by sync; otherwise one full handshake, no lockup.

Source files
------------

// File: rtl/avg_arb_pkg.sv
// ----------------------------------------------------------------------------
// avg_arb_pkg : shared FSM encodings, default widths and ring-index helper
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package avg_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int DW_DEF      = 4;
  localparam int SAMPLES_DEF = 4;
  localparam int LOG2S_DEF   = 2;

  // Folds an index in [0, 2n) back onto the ring [0, n).
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/avg_req_arbiter_if.sv
// ----------------------------------------------------------------------------
// avg_req_arbiter_if : producer req/ack/data bundle plus average output
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface avg_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 4
);
  localparam int SW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*DW-1:0] data;
  logic [NUM_REQ-1:0]    ack;
  logic                  avg_valid;
  logic [DW-1:0]         avg_data;
  logic [SW-1:0]         avg_src;

  modport master (
    output req, data,
    input  ack, avg_valid, avg_data, avg_src
  );

  modport slave (
    input  req, data,
    output ack, avg_valid, avg_data, avg_src
  );

endinterface

`default_nettype wire

// File: rtl/avg_rr_pick.sv
// ----------------------------------------------------------------------------
// avg_rr_pick : combinational round-robin picker, search starts at pointer
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module avg_rr_pick
  import avg_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int SW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_s,
  input  logic [SW-1:0]      pointer,
  output logic               any_req,
  output logic [SW-1:0]      winner
);

  logic [SW-1:0] idx;

  // Walk the ring from the farthest offset back to the pointer so the
  // closest requester is the last (and therefore final) assignment.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = SW'(rr_wrap(int'(pointer) + i, NUM_REQ));
      if (req_s[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/avg_req_arbiter.sv
// ----------------------------------------------------------------------------
// avg_req_arbiter : round-robin shares one 4-sample averager among producers
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module avg_req_arbiter
  import avg_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DW      = DW_DEF,
  parameter int SAMPLES = SAMPLES_DEF,
  parameter int LOG2S   = LOG2S_DEF
) (
  input  logic              clk_2,
  input  logic              reset_n,
  avg_req_arbiter_if.slave  bus
);

  localparam int SW = $clog2(NUM_REQ);
  localparam int AW = DW + LOG2S;

  logic [1:0]         rst_sync_q, rst_sync_d;
  logic               rst_n_int;

  logic [NUM_REQ-1:0] req_s1_q, req_s1_d;
  logic [NUM_REQ-1:0] req_s_q, req_s_d;

  state_t             state_q, state_d;
  logic [SW-1:0]      gnt_q, gnt_d;
  logic [SW-1:0]      rr_q, rr_d;

  logic [AW-1:0]      acc_q [NUM_REQ];
  logic [AW-1:0]      acc_d [NUM_REQ];
  logic [LOG2S-1:0]   cnt_q [NUM_REQ];
  logic [LOG2S-1:0]   cnt_d [NUM_REQ];

  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               avg_valid_q, avg_valid_d;
  logic [DW-1:0]      avg_data_q, avg_data_d;
  logic [SW-1:0]      avg_src_q, avg_src_d;

  logic               pick_any;
  logic [SW-1:0]      pick_idx;
  logic [DW-1:0]      sample;
  logic [AW-1:0]      sum;

  // Reset asserts asynchronously but is released two clocks later in step
  // with clk_2, so no flop sees reset removal near an edge.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n_int = rst_sync_q[1];

  avg_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SW      (SW)
  ) u_pick (
    .req_s   (req_s_q),
    .pointer (rr_q),
    .any_req (pick_any),
    .winner  (pick_idx)
  );

  assign sample = bus.data[int'(gnt_q)*DW +: DW];
  assign sum    = acc_q[gnt_q] + AW'(sample);

  always_comb begin
    req_s1_d    = bus.req;
    req_s_d     = req_s1_q;
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ack_d       = ack_q;
    avg_valid_d = 1'b0;
    avg_data_d  = avg_data_q;
    avg_src_d   = avg_src_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_idx;
          state_d = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        ack_d[gnt_q] = 1'b1;
        state_d      = ST_RELEASE;
        if (cnt_q[gnt_q] == LOG2S'(SAMPLES - 1)) begin
          avg_valid_d  = 1'b1;
          avg_data_d   = sum[AW-1:LOG2S];
          avg_src_d    = gnt_q;
          acc_d[gnt_q] = '0;
          cnt_d[gnt_q] = '0;
        end else begin
          acc_d[gnt_q] = sum;
          cnt_d[gnt_q] = cnt_q[gnt_q] + LOG2S'(1);
        end
      end

      ST_RELEASE: begin
        // Ack only drops once the producer's own synchronised req is low.
        if (!req_s_q[gnt_q]) begin
          ack_d[gnt_q] = 1'b0;
          rr_d         = SW'(rr_wrap(int'(gnt_q) + 1, NUM_REQ));
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_2 or negedge rst_n_int) begin
    if (!rst_n_int) begin
      req_s1_q    <= '0;
      req_s_q     <= '0;
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      rr_q        <= '0;
      ack_q       <= '0;
      avg_valid_q <= 1'b0;
      avg_data_q  <= '0;
      avg_src_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      req_s1_q    <= req_s1_d;
      req_s_q     <= req_s_d;
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      ack_q       <= ack_d;
      avg_valid_q <= avg_valid_d;
      avg_data_q  <= avg_data_d;
      avg_src_q   <= avg_src_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.avg_valid = avg_valid_q;
  assign bus.avg_data  = avg_data_q;
  assign bus.avg_src   = avg_src_q;

endmodule

`default_nettype wire

// File: tb/tb_avg_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_avg_req_arbiter : directed self-checking bench for avg_req_arbiter
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_avg_req_arbiter;

  localparam int NR = 4;
  localparam int DW = 4;

  logic clk_2   = 1'b0;
  logic reset_n = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  int q_src[$];
  int q_dat[$];

  avg_req_arbiter_if #(.NUM_REQ(NR), .DW(DW)) bus ();

  avg_req_arbiter #(
    .NUM_REQ (NR),
    .DW      (DW),
    .SAMPLES (4),
    .LOG2S   (2)
  ) dut (
    .clk_2   (clk_2),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Average pulses are logged here; the ack vector must never be multi-hot.
  always @(negedge clk_2) begin
    chk("ack_onehot0", 32'($onehot0(bus.ack)), 32'd1);
    if (bus.avg_valid === 1'b1) begin
      q_src.push_back(int'(bus.avg_src));
      q_dat.push_back(int'(bus.avg_data));
    end
  end

  task automatic do_reset();
    reset_n  = 1'b0;
    bus.req  = '0;
    bus.data = '0;
    repeat (3) @(posedge clk_2);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk_2);
    #1;
    q_src.delete();
    q_dat.delete();
  endtask

  task automatic send(input int p, input logic [DW-1:0] v, input bit lat);
    int n;
    @(posedge clk_2);
    #1;
    bus.data[p*DW +: DW] = v;
    bus.req[p] = 1'b1;
    if (lat) begin
      repeat (3) @(posedge clk_2);
      #1 chk("ack_not_yet", 32'(bus.ack[p]), 32'd0);
      @(posedge clk_2);
      #1 chk("ack_at_k4", 32'(bus.ack[p]), 32'd1);
    end
    n = 0;
    while (bus.ack[p] !== 1'b1 && n < 50) begin
      @(posedge clk_2);
      #1 n++;
    end
    chk("ack_rise", 32'(bus.ack[p]), 32'd1);
    bus.req[p] = 1'b0;
    if (lat) begin
      repeat (2) @(posedge clk_2);
      #1 chk("ack_held", 32'(bus.ack[p]), 32'd1);
      @(posedge clk_2);
      #1 chk("ack_fall", 32'(bus.ack[p]), 32'd0);
    end
    n = 0;
    while (bus.ack[p] !== 1'b0 && n < 50) begin
      @(posedge clk_2);
      #1 n++;
    end
    chk("ack_low", 32'(bus.ack[p]), 32'd0);
  endtask

  task automatic expect_avg(input string tag, input int src, input int dat);
    chk({tag, "_present"}, 32'(q_src.size() != 0), 32'd1);
    if (q_src.size() != 0) begin
      chk({tag, "_src"}, 32'(q_src.pop_front()), 32'(src));
      chk({tag, "_data"}, 32'(q_dat.pop_front()), 32'(dat));
    end
  endtask

  initial begin
    int n;
    int e;

    // Reset values
    do_reset();
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_avg_valid", 32'(bus.avg_valid), 32'd0);
    chk("rst_avg_data", 32'(bus.avg_data), 32'd0);
    chk("rst_avg_src", 32'(bus.avg_src), 32'd0);

    // 1: P0 3,5,7,9 -> 6, with exact ack latency
    send(0, 4'd3, 1'b1);
    send(0, 4'd5, 1'b1);
    send(0, 4'd7, 1'b1);
    chk("p0_no_early_avg", 32'(q_src.size()), 32'd0);
    send(0, 4'd9, 1'b1);
    expect_avg("p0_avg", 0, 6);

    // 2: floor and full-scale
    send(2, 4'd1, 1'b1);
    send(2, 4'd1, 1'b1);
    send(2, 4'd1, 1'b1);
    send(2, 4'd2, 1'b1);
    expect_avg("p2_floor", 2, 1);
    for (int i = 0; i < 4; i++) send(3, 4'd15, 1'b0);
    expect_avg("p3_max", 3, 15);
    chk("q_empty_2", 32'(q_src.size()), 32'd0);

    // 3: all four requesting -> cyclic grant order
    do_reset();
    bus.data = {4{4'h1}};
    bus.req  = 4'hF;
    for (int g = 0; g < 8; g++) begin
      e = g % 4;
      n = 0;
      while (bus.ack === 4'd0 && n < 50) begin
        @(posedge clk_2);
        #1 n++;
      end
      chk("rr_order", 32'(bus.ack), 32'(4'b0001 << e));
      bus.req[e] = 1'b0;
      n = 0;
      while (bus.ack !== 4'd0 && n < 50) begin
        @(posedge clk_2);
        #1 n++;
      end
      chk("rr_ack_low", 32'(bus.ack), 32'd0);
      bus.req[e] = 1'b1;
    end
    bus.req = '0;
    repeat (6) @(posedge clk_2);
    #1 chk("rr_no_avg", 32'(q_src.size()), 32'd0);

    // 4: interleaved producers keep separate sums
    do_reset();
    send(1, 4'd2, 1'b0);
    send(2, 4'd8, 1'b0);
    send(1, 4'd4, 1'b0);
    send(2, 4'd8, 1'b0);
    send(1, 4'd6, 1'b0);
    send(2, 4'd8, 1'b0);
    send(1, 4'd8, 1'b0);
    send(2, 4'd8, 1'b0);
    expect_avg("mix_p1", 1, 5);
    expect_avg("mix_p2", 2, 8);

    // 5: reset mid-handshake discards partial sums
    do_reset();
    send(1, 4'd15, 1'b0);
    send(1, 4'd15, 1'b0);
    @(posedge clk_2);
    #1 bus.data[1*DW +: DW] = 4'd4;
    bus.req[1] = 1'b1;
    n = 0;
    while (bus.ack[1] !== 1'b1 && n < 50) begin
      @(posedge clk_2);
      #1 n++;
    end
    chk("mid_ack_high", 32'(bus.ack[1]), 32'd1);
    reset_n = 1'b0;
    #1 chk("mid_rst_ack", 32'(bus.ack), 32'd0);
    bus.req = '0;
    repeat (3) @(posedge clk_2);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk_2);
    #1;
    q_src.delete();
    q_dat.delete();
    for (int i = 0; i < 4; i++) send(1, 4'd4, 1'b0);
    expect_avg("post_rst", 1, 4);
    chk("post_rst_single", 32'(q_src.size()), 32'd0);

    // 6: one-cycle glitch on req[0] must not lock the arbiter
    do_reset();
    @(posedge clk_2);
    #1 bus.data[0 +: DW] = 4'd7;
    bus.req[0] = 1'b1;
    @(posedge clk_2);
    #1 bus.req[0] = 1'b0;
    repeat (12) @(posedge clk_2);
    #1 chk("glitch_ack_clear", 32'(bus.ack), 32'd0);
    for (int i = 0; i < 4; i++) send(1, 4'd8, 1'b0);
    expect_avg("after_glitch", 1, 8);
    chk("after_glitch_single", 32'(q_src.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion, expected finish before timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
